// File: rtl/solar_display_scheduler_if.sv
// Control/status bundle between the wrapper pad logic and the display scheduler.
// master = pad-side controller, slave = solar_display_scheduler.
interface solar_display_scheduler_if #(
    parameter int DWELL_W = 16
);
    logic               enable;
    logic               manual;
    logic [2:0]         manual_sel;
    logic               hold;
    logic [DWELL_W-1:0] dwell;
    logic [4:0]         ch_mask;
    logic [2:0]         select;
    logic               sample_stb;
    logic               frame_done;
    logic               busy;

    modport master (
        output enable, manual, manual_sel, hold, dwell, ch_mask,
        input  select, sample_stb, frame_done, busy
    );

    modport slave (
        input  enable, manual, manual_sel, hold, dwell, ch_mask,
        output select, sample_stb, frame_done, busy
    );
endinterface

// File: rtl/solar_display_scheduler.sv
// Channel-select sequencer for the solar monitor's registered 5:1 display mux.
// Optional feature macro: SOLAR_SCHED_MASK_EN (honour ch_mask; otherwise all channels scan).
module solar_display_scheduler #(
    parameter int DWELL_W = 16
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    solar_display_scheduler_if.slave        bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DWELL  = 2'd2
    } state_t;

    localparam logic [2:0] CH_LAST = 3'd4;

    function automatic logic [2:0] clamp_sel(input logic [2:0] sel);
        return (sel > CH_LAST) ? 3'd0 : sel;
    endfunction

    function automatic logic [2:0] lowest_ch(input logic [4:0] elig);
        logic [2:0] ch;
        ch = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            ch = elig[i] ? 3'(i) : ch;
        end
        return ch;
    endfunction

    // Returns {found, channel}: lowest eligible channel strictly above cur.
    function automatic logic [3:0] next_above(input logic [2:0] cur, input logic [4:0] elig);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            res = (elig[i] && (i > int'(cur))) ? {1'b1, 3'(i)} : res;
        end
        return res;
    endfunction

    logic [4:0]         eligible_s;
    logic [2:0]         manual_tgt_s;
    logic [2:0]         lowest_s;
    logic [3:0]         next_s;
    logic [DWELL_W-1:0] load_s;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [2:0]         select_r;
    logic [2:0]         select_nxt_s;
    logic [DWELL_W-1:0] count_r;
    logic [DWELL_W-1:0] count_nxt_s;
    logic               stb_r;
    logic               stb_nxt_s;
    logic               frame_r;
    logic               frame_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;

`ifdef SOLAR_SCHED_MASK_EN
    assign eligible_s = bus.ch_mask;
`else
    // Mask has no effect in this build: every channel is always eligible.
    assign eligible_s = bus.ch_mask | 5'b11111;
`endif

    assign manual_tgt_s = clamp_sel(bus.manual_sel);
    assign lowest_s     = lowest_ch(eligible_s);
    assign next_s       = next_above(select_r, eligible_s);
    assign load_s       = (bus.dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                        : bus.dwell - {{(DWELL_W-1){1'b0}}, 1'b1};

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s  = state_r;
        select_nxt_s = select_r;
        count_nxt_s  = count_r;
        stb_nxt_s    = 1'b0;
        frame_nxt_s  = 1'b0;
        if (!bus.enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.manual) begin
                        select_nxt_s = manual_tgt_s;
                        state_nxt_s  = ST_SETTLE;
                    end else if (|eligible_s) begin
                        select_nxt_s = lowest_s;
                        state_nxt_s  = ST_SETTLE;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    stb_nxt_s   = 1'b1;
                    count_nxt_s = load_s;
                    state_nxt_s = ST_DWELL;
                end
                ST_DWELL: begin
                    if (bus.manual && (manual_tgt_s != select_r)) begin
                        select_nxt_s = manual_tgt_s;
                        state_nxt_s  = ST_SETTLE;
                    end else if (bus.hold) begin
                        count_nxt_s  = count_r;
                    end else if (count_r != {DWELL_W{1'b0}}) begin
                        count_nxt_s  = count_r - {{(DWELL_W-1){1'b0}}, 1'b1};
                    end else if (bus.manual) begin
                        // Manual expiry only restarts the dwell; the channel stays pinned.
                        count_nxt_s  = load_s;
                    end else if (!(|eligible_s)) begin
                        state_nxt_s  = ST_IDLE;
                    end else if (next_s[3]) begin
                        select_nxt_s = next_s[2:0];
                        state_nxt_s  = ST_SETTLE;
                    end else begin
                        select_nxt_s = lowest_s;
                        frame_nxt_s  = 1'b1;
                        state_nxt_s  = ST_SETTLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State register and registered outputs; reset clears everything with no strobe.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r  <= ST_IDLE;
            select_r <= 3'd0;
            count_r  <= {DWELL_W{1'b0}};
            stb_r    <= 1'b0;
            frame_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            select_r <= select_nxt_s;
            count_r  <= count_nxt_s;
            stb_r    <= stb_nxt_s;
            frame_r  <= frame_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign bus.select     = select_r;
    assign bus.sample_stb = stb_r;
    assign bus.frame_done = frame_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_solar_display_scheduler.sv
// Directed self-checking bench for solar_display_scheduler.
module tb_solar_display_scheduler;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    solar_display_scheduler_if #(.DWELL_W(16)) bus ();

    solar_display_scheduler #(.DWELL_W(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.manual     = 1'b0;
        bus.manual_sel = 3'd0;
        bus.hold       = 1'b0;
        bus.dwell      = 16'd3;
        bus.ch_mask    = 5'b11111;

        // Reset state
        repeat (2) tick();
        check("rst_sel",   bus.select,     0);
        check("rst_stb",   bus.sample_stb, 0);
        check("rst_frame", bus.frame_done, 0);
        check("rst_busy",  bus.busy,       0);
        rst = 1'b0;

        // Auto scan, dwell 3: 4 cycles per channel, frame every 20 cycles
        bus.enable = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            check("t1_sel",   bus.select,     ((k - 1) / 4) % 5);
            check("t1_stb",   bus.sample_stb, ((k - 1) % 4) == 1);
            check("t1_frame", bus.frame_done, (k > 1) && (((k - 1) % 20) == 0));
            check("t1_busy",  bus.busy,       1);
        end
        bus.enable = 1'b0;
        tick();
        check("dis_busy", bus.busy,       0);
        check("dis_sel",  bus.select,     1);
        check("dis_stb",  bus.sample_stb, 0);

        // Dwell 0 behaves as 1: 2 cycles per channel
        bus.dwell  = 16'd0;
        bus.enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t2_sel",   bus.select,     ((k - 1) / 2) % 5);
            check("t2_stb",   bus.sample_stb, ((k - 1) % 2) == 1);
            check("t2_frame", bus.frame_done, (k > 1) && (((k - 1) % 10) == 0));
        end
        bus.enable = 1'b0;
        tick();
        check("t2_idle", bus.busy, 0);

        // Manual mode: channel 3, then out-of-range 6 clamps to 0
        bus.dwell      = 16'd3;
        bus.manual     = 1'b1;
        bus.manual_sel = 3'd3;
        bus.enable     = 1'b1;
        tick();
        check("m_sel3",     bus.select,     3);
        check("m_stb0",     bus.sample_stb, 0);
        tick();
        check("m_stb3",     bus.sample_stb, 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("m_hold3",  bus.select,     3);
            check("m_nostb",  bus.sample_stb, 0);
            check("m_noframe", bus.frame_done, 0);
        end
        bus.manual_sel = 3'd6;
        tick();
        check("m_sel0",     bus.select,     0);
        check("m_stb_lag",  bus.sample_stb, 0);
        tick();
        check("m_stb0b",    bus.sample_stb, 1);
        check("m_noframe2", bus.frame_done, 0);
        tick();
        check("m_stb_off",  bus.sample_stb, 0);

        // Manual to auto: next expiry advances from 0 to 1
        bus.manual = 1'b0;
        tick();
        check("ma_sel0",  bus.select,     0);
        tick();
        check("ma_sel1",  bus.select,     1);
        check("ma_frame", bus.frame_done, 0);
        bus.enable = 1'b0;
        tick();

        // Hold for 5 cycles stretches channel 0 to 8 cycles
        bus.dwell  = 16'd2;
        bus.enable = 1'b1;
        tick();
        check("h_sel0", bus.select, 0);
        tick();
        check("h_stb",  bus.sample_stb, 1);
        bus.hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("h_frozen", bus.select, 0);
        end
        bus.hold = 1'b0;
        tick();
        check("h_last0",  bus.select,     0);
        tick();
        check("h_sel1",   bus.select,     1);
        tick();
        check("h_stb1",   bus.sample_stb, 1);
        tick();
        check("h_keep1",  bus.select,     1);
        tick();
        check("h_sel2",   bus.select,     2);
        tick();
        check("h_stb2",   bus.sample_stb, 1);

        // Asynchronous reset mid-dwell on channel 2
        rst = 1'b1;
        #1;
        check("ar_sel",   bus.select,     0);
        check("ar_stb",   bus.sample_stb, 0);
        check("ar_frame", bus.frame_done, 0);
        check("ar_busy",  bus.busy,       0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_r_sel0", bus.select,     0);
        check("ar_r_busy", bus.busy,       1);
        tick();
        check("ar_r_stb",  bus.sample_stb, 1);
        tick();
        check("ar_r_keep", bus.select,     0);
        tick();
        check("ar_r_sel1", bus.select,     1);

`ifdef SOLAR_SCHED_MASK_EN
        // Sparse mask alternates 2 and 4; clearing it ends in IDLE after the dwell
        bus.enable = 1'b0;
        tick();
        bus.ch_mask = 5'b10100;
        bus.enable  = 1'b1;
        tick();
        check("mk_sel2",  bus.select,     2);
        repeat (3) tick();
        check("mk_sel4",  bus.select,     4);
        check("mk_nofr",  bus.frame_done, 0);
        repeat (3) tick();
        check("mk_wrap2", bus.select,     2);
        check("mk_frame", bus.frame_done, 1);
        bus.ch_mask = 5'b00000;
        tick();
        check("mk_stb",   bus.sample_stb, 1);
        check("mk_busy1", bus.busy,       1);
        repeat (2) tick();
        check("mk_idle",  bus.busy,       0);
        check("mk_held",  bus.select,     2);
        bus.ch_mask = 5'b11111;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
